// File: rtl/harness_pkg.sv
// Shared types and default region table for the program sequencer harness.
package harness_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, DONE} state_e;

  localparam int PROG_W = 4;

  localparam int                DEF_NUM_REGIONS = 4;
  localparam logic [4*8-1:0]    DEF_REGION_BASE = {8'd128, 8'd32, 8'd6, 8'd1};
  localparam logic [4*9-1:0]    DEF_REGION_LEN  = {9'd20, 9'd64, 9'd1, 9'd3};

endpackage

// File: rtl/program_sequencer_region_walker.sv
// Steps through a table of address regions one word per advance, skipping empty regions.
module region_walker
  import harness_pkg::*;
#(
  parameter int                            AW          = 8,
  parameter int                            NUM_REGIONS = DEF_NUM_REGIONS,
  parameter logic [NUM_REGIONS*AW-1:0]     REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*(AW+1)-1:0] REGION_LEN  = DEF_REGION_LEN
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          advance_i,
  output logic [AW-1:0] addr_o,
  output logic          valid_o,
  output logic          last_o,
  output logic          empty_o
);

  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

  logic [RW-1:0] reg_q, reg_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d;

  logic          first_found, next_found;
  logic [RW-1:0] first_idx, next_idx;

  function automatic logic [AW-1:0] base_of(input int r);
    return REGION_BASE[r*AW +: AW];
  endfunction

  function automatic logic [AW:0] len_of(input int r);
    return REGION_LEN[r*(AW+1) +: (AW+1)];
  endfunction

  // Descending scan leaves the lowest qualifying index in first_idx / next_idx.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (len_of(r) != '0) begin
        first_found = 1'b1;
        first_idx   = RW'(r);
        if (r > int'(reg_q)) begin
          next_found = 1'b1;
          next_idx   = RW'(r);
        end
      end
    end
  end

  always_comb begin
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    if (load_i) begin
      reg_d   = first_idx;
      addr_d  = base_of(int'(first_idx));
      cnt_d   = len_of(int'(first_idx));
      valid_d = first_found;
    end else if (advance_i && valid_q) begin
      if (cnt_q > LEN_ONE) begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 1'b1;
      end else if (next_found) begin
        reg_d  = next_idx;
        addr_d = base_of(int'(next_idx));
        cnt_d  = len_of(int'(next_idx));
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign addr_o  = addr_q;
  assign valid_o = valid_q;
  assign last_o  = valid_q && (cnt_q == LEN_ONE) && !next_found;
  assign empty_o = !first_found;

endmodule

// File: rtl/program_sequencer.sv
// Test-harness sequencer: rotates program index, copies image regions into core
// data memory, then releases the core and waits for done or a watchdog timeout.
module program_sequencer
  import harness_pkg::*;
#(
  parameter int                            NUM_PROGS   = 3,
  parameter int                            AW          = 8,
  parameter int                            DW          = 8,
  parameter int                            NUM_REGIONS = DEF_NUM_REGIONS,
  parameter logic [NUM_REGIONS*AW-1:0]     REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*(AW+1)-1:0] REGION_LEN  = DEF_REGION_LEN,
  parameter int                            TIMEOUT     = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic [PROG_W-1:0] prog_idx,
  output logic [AW-1:0]     img_addr,
  input  logic [DW-1:0]     img_rdata,
  output logic              dm_we,
  output logic [AW-1:0]     dm_addr,
  output logic [DW-1:0]     dm_wdata,
  output logic              core_init,
  input  logic              core_done,
  output logic              done,
  output logic              err,
  output logic [AW:0]       words_loaded
);

  state_e            state_q;
  logic [PROG_W-1:0] prog_q;
  logic              busy_q, done_q, err_q, core_init_q, dm_we_q;
  logic [AW-1:0]     dm_addr_q;
  logic [AW:0]       words_q;
  logic [31:0]       wd_q;

  logic          accept;
  logic [AW-1:0] wlk_addr;
  logic          wlk_valid, wlk_last, wlk_empty;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  region_walker #(
    .AW          (AW),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_LEN  (REGION_LEN)
  ) u_walker (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (accept),
    .advance_i (state_q == LOAD),
    .addr_o    (wlk_addr),
    .valid_o   (wlk_valid),
    .last_o    (wlk_last),
    .empty_o   (wlk_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prog_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      core_init_q <= 1'b1;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      words_q     <= '0;
      wd_q        <= '0;
    end else begin
      // Write stage trails the address stage by one cycle to match the image read latency.
      dm_we_q <= (state_q == LOAD);
      if (state_q == LOAD) dm_addr_q <= wlk_addr;
      if (dm_we_q) words_q <= words_q + 1'b1;

      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            prog_q  <= (prog_q == PROG_W'(NUM_PROGS)) ? PROG_W'(1) : prog_q + 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= '0;
            if (wlk_empty) begin
              state_q     <= RUN;
              core_init_q <= 1'b0;
              wd_q        <= '0;
            end else begin
              state_q     <= LOAD;
              core_init_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (wlk_last || !wlk_valid) state_q <= DRAIN;
        end
        DRAIN: begin
          state_q     <= RUN;
          core_init_q <= 1'b0;
          wd_q        <= '0;
        end
        RUN: begin
          wd_q <= wd_q + 32'd1;
          // The first RUN cycle may still see the previous run's done level.
          if ((wd_q != '0) && core_done) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
          end else if ((TIMEOUT != 0) && ((wd_q + 32'd1) == 32'(TIMEOUT))) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            core_init_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign prog_idx     = prog_q;
  assign img_addr     = wlk_addr;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_wdata     = img_rdata;
  assign core_init    = core_init_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Synthesizable test-harness sequencer for running a sequence of programs on the core.
- On each accepted start it does three things:
  - advances the program index through 1..NUM_PROGS, wrapping back to 1;
  - copies a configurable list of address regions from an image memory into the core data memory;
  - pulses the core's init, then waits for core done or a watchdog timeout.
- Sits between the bench/host and the top-level core.
- Parametrised successor to the fixed three-program harness: adds region tables, timeout, error reporting and a busy handshake.

Parameters:
- NUM_PROGS, 3, number of programs to rotate through (1..15).
- AW, 8, address width of image and data memory.
- DW, 8, data word width.
- NUM_REGIONS, 4, number of entries in the copy-region table.
- REGION_BASE, {1,6,32,128}, per-region start address (NUM_REGIONS x AW).
- REGION_LEN, {3,1,64,20}, per-region word count (NUM_REGIONS x (AW+1)); 0 means skip the region.
- TIMEOUT, 65535, maximum RUN cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run the next program.
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- prog_idx  out  4  current program number; 0 after reset.
- img_addr  out  AW  image memory read address.
- img_rdata  in  DW  image read data; synchronous read, valid 1 cycle after img_addr.
- dm_we  out  1  core data-memory write enable.
- dm_addr  out  AW  core data-memory write address.
- dm_wdata  out  DW  core data-memory write data.
- core_init  out  1  core init/hold; the core starts on its falling edge.
- core_done  in  1  core completion flag (level).
- done  out  1  run finished; held until the next accepted start.
- err  out  1  the last run timed out; valid while done=1.
- words_loaded  out  AW+1  number of words written in the current/last load.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state = IDLE;
  - prog_idx = 0, busy = 0, done = 0, err = 0;
  - dm_we = 0, core_init = 1;
  - img_addr = 0, dm_addr = 0, words_loaded = 0.
- States: IDLE, LOAD, DRAIN, RUN, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE; it is ignored in LOAD, DRAIN and RUN.
  - On acceptance, prog_idx becomes (prog_idx==NUM_PROGS) ? 1 : prog_idx+1. The first run is therefore program 1, and 0 is never revisited.
  - Acceptance also clears done, err and words_loaded, and sets busy and core_init.
- LOAD:
  - Walks the regions in ascending table order; within a region, addresses ascend from REGION_BASE to REGION_BASE+REGION_LEN-1.
  - Regions with zero length are skipped with no cycle spent on them.
  - Each cycle issues one img_addr.
  - On the following cycle: dm_we = 1, dm_addr = the address issued one cycle earlier, dm_wdata = img_rdata. Image and data memory addresses are identical.
  - The cycle after the last address is issued, go to DRAIN.
  - If every region has length 0, go straight from start acceptance to RUN with no writes.
- DRAIN:
  - Performs the final write, then goes to RUN.
  - Load throughput is 1 word/cycle; LOAD+DRAIN take (sum of REGION_LEN)+1 cycles. With the defaults that is 88 writes over 89 cycles.
- Address rules:
  - Addresses wrap modulo 2^AW, so base+len overflow wraps.
  - Overlapping regions are written twice, in table order.
- words_loaded increments on every dm_we.
- RUN:
  - core_init drops to 0 on the first RUN cycle; the watchdog counter clears to 0.
  - core_done is ignored during the first RUN cycle, because the core's previous done may still be high.
  - From the second cycle on: core_done = 1 → DONE with err = 0.
  - If the counter reaches TIMEOUT (TIMEOUT != 0) → DONE with err = 1 and core_init forced to 1.
  - If core_done and the timeout coincide, done wins (err = 0).
- DONE:
  - done = 1, busy = 0.
  - core_init stays 0 after a normal finish and 1 after a timeout.
  - A start in DONE follows the acceptance rules above.
- Reset mid-operation: immediate return to IDLE with reset values. A partial load is not repaired; the next run reloads everything.
- dm_we is never asserted outside LOAD/DRAIN.

Decomposition:
- Shared package harness_pkg holds:
  - the state enum state_e;
  - the default region table constants DEF_REGION_BASE and DEF_REGION_LEN;
  - the localparam for the index width.
- One sub-module, region_walker: given the region table, it produces addr, valid and last with skip-empty logic. The sequencer keeps the FSM, rotation, watchdog and write pipeline.

Test Plan:
- Defaults; image[a] = a^8'h5A; one start:
  - dm_we pulses 88 times, at addrs 1-3, 6, 32-95, 128-147 in order, with wdata = addr^8'h5A;
  - core_init falls on the 90th cycle after start;
  - prog_idx = 1.
- Four runs, core_done raised 10 cycles into RUN each time:
  - prog_idx sequence 1,2,3,1;
  - done holds between runs;
  - a start pulsed during LOAD is ignored (prog_idx unchanged, no extra writes).
- TIMEOUT = 20, core_done held 0:
  - DONE after 20 RUN cycles, err = 1, core_init = 1;
  - the next start gives err = 0 and a fresh load.
- REGION_LEN = {0,0,0,0}: start → RUN on the next cycle, zero dm_we, words_loaded = 0.
- Region base 250, len 10: writes to 250..255 then 0..3; words_loaded = 10.
- rst_n low at the 40th LOAD cycle:
  - async clear;
  - dm_we = 0 within the same cycle;
  - prog_idx = 0; the next start runs program 1.
